snake_food_placer: RTL and testbench
====================================

SNAKE_FOOD_PLACER -- requirements
Module: snake_food_placer

Interface
REQ-001 Parameter GRID_W, default 32: playfield width in cells; X coordinate = RandNum[4:0].
REQ-002 Parameter GRID_H, default 24: playfield height in cells; Y coordinate = RandNum[9:5].
REQ-003 Parameter MAX_TRIES, default 16: candidate draws allowed per placement before failure.
REQ-004 Parameter WDOG_CYC, default 16: maximum wait cycles for a random-number response.
REQ-005 i_Clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 i_Rst  in  1  asynchronous, active-high reset.
REQ-007 i_PlaceReq  in  1  one-cycle request to place a new food item.
REQ-008 o_RandNeed  out  1  one-cycle request to the random-number generator.
REQ-009 i_RandNum  in  14  random value; valid while i_isRanDone=1.
REQ-010 i_isRanDone  in  1  random value ready.
REQ-011 o_QueryX / o_QueryY  out  5 / 5  cell address presented to the snake occupancy map.
REQ-012 i_Occupied  in  1  occupancy of the queried cell; valid one cycle after the address is presented.
REQ-013 o_FoodX / o_FoodY  out  5 / 5  placed food cell.
REQ-014 o_FoodValid  out  1  food position is valid.
REQ-015 o_PlaceDone / o_PlaceFail  out  1 / 1  one-cycle completion or failure pulses.
REQ-016 o_Busy  out  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have six states: IDLE, REQ, WAIT, QUERY, CHECK, FIN.
REQ-018 IDLE: when i_PlaceReq=1, the FSM SHALL clear o_FoodValid, clear the try and watchdog counters, and go to REQ; otherwise it stays in IDLE.
REQ-019 REQ: o_RandNeed SHALL be 1 for exactly this cycle; the FSM then goes to WAIT and clears the watchdog counter.
REQ-020 WAIT: when i_isRanDone=1, the FSM SHALL capture X=i_RandNum[4:0] and Y=i_RandNum[9:5]; it goes to QUERY if X<GRID_W and Y<GRID_H; otherwise it counts a rejected try.
REQ-021 WAIT: the watchdog SHALL increment each cycle; on reaching WDOG_CYC without i_isRanDone, the FSM pulses o_PlaceFail and returns to IDLE.
REQ-022 QUERY: o_QueryX/o_QueryY SHALL hold the candidate; the FSM goes to CHECK next cycle, and the address is held through CHECK.
REQ-023 CHECK: if i_Occupied=0, the FSM SHALL load o_FoodX/o_FoodY with the candidate and go to FIN; if i_Occupied=1, it counts a rejected try.
REQ-024 Rejected try: the try counter SHALL increment; if the new count equals MAX_TRIES, the FSM pulses o_PlaceFail and returns to IDLE with o_FoodValid=0; otherwise it returns to REQ.
REQ-025 FIN: o_FoodValid SHALL be set, and o_PlaceDone SHALL be 1 for this cycle only; the FSM returns to IDLE.
REQ-026 Latency with a generator answering 2 cycles after o_RandNeed and no rejections: o_PlaceDone SHALL be asserted 6 cycles after the cycle in which i_PlaceReq is sampled.
REQ-027 i_PlaceReq while o_Busy=1 SHALL be ignored, with no queuing.
REQ-028 o_FoodX/o_FoodY SHALL hold their last placed value across failures and new requests until a successful CHECK.
REQ-029 i_isRanDone SHALL be ignored outside WAIT, and i_Occupied SHALL be ignored outside CHECK.
REQ-030 The try counter SHALL be 5 bits wide, supporting MAX_TRIES up to 31.

Reset
REQ-031 On i_Rst=1 the block SHALL enter IDLE immediately and asynchronously, including mid-operation.
REQ-032 On reset, all outputs SHALL be 0: o_FoodX, o_FoodY, o_QueryX, o_QueryY, o_FoodValid, o_RandNeed, o_PlaceDone, o_PlaceFail, o_Busy.
REQ-033 On reset, the try and watchdog counters SHALL be 0.

Structure
REQ-034 Shared package snake_pkg SHALL hold GRID_W, GRID_H, the coordinate width (5), the random-number width (14), and the placer state encoding.
REQ-035 The block SHALL be a single module with no sub-module; the random-number generator and occupancy map are instantiated externally by the game top.

Verification
REQ-036 Free placement: reset, pulse i_PlaceReq, model returns 14'h0145, cell free -> o_FoodX=5, o_FoodY=10, o_FoodValid=1, one o_PlaceDone pulse 6 cycles after the request.
REQ-037 Out-of-range draw: first draw 14'h0300 (Y=24) then 14'h0022 -> no query issued for the first draw, second o_RandNeed pulse, result X=2, Y=1.
REQ-038 Occupied retry: i_Occupied=1 for the first 3 candidates, 0 for the 4th -> exactly 4 o_RandNeed pulses, placement equals the 4th candidate.
REQ-039 Exhaustion: i_Occupied always 1 -> 16 o_RandNeed pulses, then o_PlaceFail, o_FoodValid=0, previous o_FoodX/o_FoodY unchanged.
REQ-040 Watchdog: i_isRanDone never asserted -> o_PlaceFail exactly 16 cycles after entering WAIT, then o_Busy=0.
REQ-041 Reset mid-operation: assert i_Rst while in WAIT, plus i_PlaceReq pulsed while busy -> all outputs 0 immediately, and the busy-time request produces no extra placement.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game: playfield geometry, bus widths
// and the food placer state encoding.
package snake_pkg;

    localparam int GRID_W  = 32;
    localparam int GRID_H  = 24;
    localparam int COORD_W = 5;
    localparam int RAND_W  = 14;
    localparam int TRY_W   = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_QUERY,
        ST_CHECK,
        ST_FIN
    } placer_state_t;

endpackage

// File: rtl/snake_food_placer.sv
// Picks a free playfield cell for a new food item by drawing random candidates
// and probing the snake occupancy map, giving up after too many misses.
module snake_food_placer
    import snake_pkg::*;
#(
    parameter int GRID_W    = snake_pkg::GRID_W,
    parameter int GRID_H    = snake_pkg::GRID_H,
    parameter int MAX_TRIES = 16,
    parameter int WDOG_CYC  = 16
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               i_PlaceReq,
    output logic               o_RandNeed,
    input  logic [RAND_W-1:0]  i_RandNum,
    input  logic               i_isRanDone,
    output logic [COORD_W-1:0] o_QueryX,
    output logic [COORD_W-1:0] o_QueryY,
    input  logic               i_Occupied,
    output logic [COORD_W-1:0] o_FoodX,
    output logic [COORD_W-1:0] o_FoodY,
    output logic               o_FoodValid,
    output logic               o_PlaceDone,
    output logic               o_PlaceFail,
    output logic               o_Busy
);

    localparam int WDOG_W = $clog2(WDOG_CYC + 1);

    placer_state_t        state;
    logic [TRY_W-1:0]     try_cnt;
    logic [WDOG_W-1:0]    wdog_cnt;
    logic [COORD_W-1:0]   rand_x;
    logic [COORD_W-1:0]   rand_y;
    logic                 rand_in_range;
    logic                 reject;
    logic                 last_try;
    logic                 unused_rand_msbs;

    assign rand_x           = i_RandNum[COORD_W-1:0];
    assign rand_y           = i_RandNum[2*COORD_W-1:COORD_W];
    assign unused_rand_msbs = ^i_RandNum[RAND_W-1:2*COORD_W];
    assign rand_in_range    = (int'(rand_x) < GRID_W) && (int'(rand_y) < GRID_H);
    assign last_try         = (try_cnt + TRY_W'(1)) == TRY_W'(MAX_TRIES);

    // A try is spent either on an off-grid draw or on a cell the snake covers.
    assign reject = ((state == ST_WAIT) && i_isRanDone && !rand_in_range) ||
                    ((state == ST_CHECK) && i_Occupied);

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state       <= ST_IDLE;
            try_cnt     <= '0;
            wdog_cnt    <= '0;
            o_RandNeed  <= 1'b0;
            o_QueryX    <= '0;
            o_QueryY    <= '0;
            o_FoodX     <= '0;
            o_FoodY     <= '0;
            o_FoodValid <= 1'b0;
            o_PlaceDone <= 1'b0;
            o_PlaceFail <= 1'b0;
            o_Busy      <= 1'b0;
        end else begin
            o_RandNeed  <= 1'b0;
            o_PlaceDone <= 1'b0;
            o_PlaceFail <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (i_PlaceReq) begin
                        o_FoodValid <= 1'b0;
                        try_cnt     <= '0;
                        wdog_cnt    <= '0;
                        o_RandNeed  <= 1'b1;
                        o_Busy      <= 1'b1;
                        state       <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    wdog_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_isRanDone) begin
                        if (rand_in_range) begin
                            o_QueryX <= rand_x;
                            o_QueryY <= rand_y;
                            state    <= ST_QUERY;
                        end
                    end else if (wdog_cnt == WDOG_W'(WDOG_CYC - 1)) begin
                        o_PlaceFail <= 1'b1;
                        o_Busy      <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        wdog_cnt <= wdog_cnt + WDOG_W'(1);
                    end
                end
                ST_QUERY: begin
                    state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (!i_Occupied) begin
                        o_FoodX     <= o_QueryX;
                        o_FoodY     <= o_QueryY;
                        o_FoodValid <= 1'b1;
                        o_PlaceDone <= 1'b1;
                        state       <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    o_Busy <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    o_Busy <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase

            // Later assignments win, so a rejection overrides the per-state next state.
            if (reject) begin
                try_cnt <= try_cnt + TRY_W'(1);
                if (last_try) begin
                    o_PlaceFail <= 1'b1;
                    o_Busy      <= 1'b0;
                    state       <= ST_IDLE;
                end else begin
                    o_RandNeed <= 1'b1;
                    state      <= ST_REQ;
                end
            end
        end
    end

endmodule

// File: tb/tb_snake_food_placer.sv
// Self-checking bench for snake_food_placer: models the random generator and
// the occupancy map, and scores each placement against a queue of expected outcomes.
module tb_snake_food_placer;
    import snake_pkg::*;

    logic        i_Clk = 1'b0;
    logic        i_Rst = 1'b1;
    logic        i_PlaceReq = 1'b0;
    logic        o_RandNeed;
    logic [13:0] i_RandNum = '0;
    logic        i_isRanDone = 1'b0;
    logic [4:0]  o_QueryX;
    logic [4:0]  o_QueryY;
    logic        i_Occupied = 1'b0;
    logic [4:0]  o_FoodX;
    logic [4:0]  o_FoodY;
    logic        o_FoodValid;
    logic        o_PlaceDone;
    logic        o_PlaceFail;
    logic        o_Busy;

    typedef struct {
        bit         fail;
        logic [4:0] x;
        logic [4:0] y;
        int         needs;
        int         latency;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          fails = 0;
    int          need_total = 0;
    int          done_total = 0;
    int          fail_total = 0;
    int          y24_total = 0;
    int          gen_delay = 0;
    bit          gen_enable = 1'b1;
    logic [13:0] rand_tab [0:63];
    int          rand_wr = 0;
    int          rand_rd = 0;
    bit          occ_map [0:1023];
    bit          occ_all = 1'b0;

    snake_food_placer dut (
        .i_Clk       (i_Clk),
        .i_Rst       (i_Rst),
        .i_PlaceReq  (i_PlaceReq),
        .o_RandNeed  (o_RandNeed),
        .i_RandNum   (i_RandNum),
        .i_isRanDone (i_isRanDone),
        .o_QueryX    (o_QueryX),
        .o_QueryY    (o_QueryY),
        .i_Occupied  (i_Occupied),
        .o_FoodX     (o_FoodX),
        .o_FoodY     (o_FoodY),
        .o_FoodValid (o_FoodValid),
        .o_PlaceDone (o_PlaceDone),
        .o_PlaceFail (o_PlaceFail),
        .o_Busy      (o_Busy)
    );

    always #5 i_Clk = ~i_Clk;

    // Generator model: answers each o_RandNeed two cycles later with the next queued value.
    always @(negedge i_Clk) begin
        i_isRanDone = 1'b0;
        if (gen_delay == 1) begin
            i_isRanDone = 1'b1;
            if (rand_rd < rand_wr) begin
                i_RandNum = rand_tab[rand_rd % 64];
                rand_rd++;
            end else begin
                i_RandNum = 14'h3fff;
            end
        end
        if (gen_delay > 0) gen_delay--;
        if (o_RandNeed) begin
            need_total++;
            if (gen_enable) gen_delay = 2;
        end
    end

    // Occupancy model and pulse monitors.
    always @(negedge i_Clk) begin
        if (o_PlaceDone) done_total++;
        if (o_PlaceFail) fail_total++;
        if (o_Busy && o_QueryY == 5'd24) y24_total++;
        i_Occupied = occ_all || occ_map[{o_QueryY, o_QueryX}];
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, got hang expected completion");
        $fatal(1, "[TB] global timeout");
    end

    task automatic push_rand(input logic [4:0] x, input logic [4:0] y);
        rand_tab[rand_wr % 64] = {4'b0, y, x};
        rand_wr++;
    endtask

    task automatic clear_map();
        foreach (occ_map[i]) occ_map[i] = 1'b0;
        occ_all = 1'b0;
    endtask

    task automatic pulse_request();
        @(negedge i_Clk);
        i_PlaceReq = 1'b1;
        @(negedge i_Clk);
        i_PlaceReq = 1'b0;
    endtask

    task automatic wait_outcome(input int budget, output int cycles, output bit timed_out);
        cycles = 1;
        while (!(o_PlaceDone || o_PlaceFail) && cycles < budget) begin
            @(negedge i_Clk);
            cycles++;
        end
        timed_out = !(o_PlaceDone || o_PlaceFail);
    endtask

    task automatic test_reset();
        i_Rst = 1'b1;
        repeat (3) @(negedge i_Clk);
        checks++;
        if ({o_FoodX, o_FoodY} !== 10'd0) begin
            fails++;
            $display("[TB] FAIL reset_food_xy: got %h expected 000", {o_FoodX, o_FoodY});
        end
        checks++;
        if ({o_QueryX, o_QueryY} !== 10'd0) begin
            fails++;
            $display("[TB] FAIL reset_query_xy: got %h expected 000", {o_QueryX, o_QueryY});
        end
        checks++;
        if ({o_FoodValid, o_RandNeed, o_PlaceDone, o_PlaceFail, o_Busy} !== 5'b0) begin
            fails++;
            $display("[TB] FAIL reset_flags: got %b expected 00000",
                     {o_FoodValid, o_RandNeed, o_PlaceDone, o_PlaceFail, o_Busy});
        end
        i_Rst = 1'b0;
        repeat (3) @(negedge i_Clk);
        checks++;
        if (o_Busy !== 1'b0 || need_total != 0) begin
            fails++;
            $display("[TB] FAIL idle_after_reset: got busy=%b needs=%0d expected busy=0 needs=0",
                     o_Busy, need_total);
        end
    endtask

    task automatic test_free_placement();
        int   cyc;
        bit   to;
        int   need_base;
        exp_t e;
        clear_map();
        need_base = need_total;
        push_rand(5'd5, 5'd10);
        exp_q.push_back('{1'b0, 5'd5, 5'd10, 1, 6});
        pulse_request();
        wait_outcome(60, cyc, to);
        e = exp_q.pop_front();
        checks++;
        if (to) begin
            fails++;
            $display("[TB] FAIL free_timeout: got no completion expected done");
        end
        checks++;
        if ({o_PlaceFail, o_PlaceDone, o_FoodValid, o_Busy, o_FoodX, o_FoodY} !==
            {e.fail, !e.fail, !e.fail, !e.fail, e.x, e.y}) begin
            fails++;
            $display("[TB] FAIL free_outcome: got fail=%b done=%b valid=%b busy=%b x=%0d y=%0d expected x=%0d y=%0d",
                     o_PlaceFail, o_PlaceDone, o_FoodValid, o_Busy, o_FoodX, o_FoodY, e.x, e.y);
        end
        checks++;
        if (need_total - need_base != e.needs) begin
            fails++;
            $display("[TB] FAIL free_needs: got %0d expected %0d", need_total - need_base, e.needs);
        end
        checks++;
        if (cyc != e.latency) begin
            fails++;
            $display("[TB] FAIL free_latency: got %0d expected %0d", cyc, e.latency);
        end
        @(negedge i_Clk);
        checks++;
        if ({o_PlaceDone, o_Busy, o_FoodValid} !== 3'b001) begin
            fails++;
            $display("[TB] FAIL free_after: got done/busy/valid=%b expected 001",
                     {o_PlaceDone, o_Busy, o_FoodValid});
        end
    endtask

    task automatic test_out_of_range();
        int   cyc;
        bit   to;
        int   need_base;
        int   y24_base;
        exp_t e;
        clear_map();
        need_base = need_total;
        y24_base  = y24_total;
        push_rand(5'd0, 5'd24);
        push_rand(5'd2, 5'd1);
        exp_q.push_back('{1'b0, 5'd2, 5'd1, 2, -1});
        pulse_request();
        wait_outcome(100, cyc, to);
        e = exp_q.pop_front();
        checks++;
        if (to || {o_PlaceFail, o_PlaceDone, o_FoodValid, o_FoodX, o_FoodY} !==
                  {e.fail, !e.fail, !e.fail, e.x, e.y}) begin
            fails++;
            $display("[TB] FAIL range_outcome: got timeout=%b done=%b x=%0d y=%0d expected x=%0d y=%0d",
                     to, o_PlaceDone, o_FoodX, o_FoodY, e.x, e.y);
        end
        checks++;
        if (need_total - need_base != e.needs) begin
            fails++;
            $display("[TB] FAIL range_needs: got %0d expected %0d", need_total - need_base, e.needs);
        end
        checks++;
        if (y24_total != y24_base) begin
            fails++;
            $display("[TB] FAIL range_no_query: got %0d off-grid query cycles expected 0",
                     y24_total - y24_base);
        end
    endtask

    task automatic test_occupied_retry();
        int   cyc;
        bit   to;
        int   need_base;
        exp_t e;
        clear_map();
        occ_map[{5'd4, 5'd3}] = 1'b1;
        occ_map[{5'd8, 5'd7}] = 1'b1;
        occ_map[{5'd1, 5'd9}] = 1'b1;
        need_base = need_total;
        push_rand(5'd3, 5'd4);
        push_rand(5'd7, 5'd8);
        push_rand(5'd9, 5'd1);
        push_rand(5'd12, 5'd20);
        exp_q.push_back('{1'b0, 5'd12, 5'd20, 4, -1});
        pulse_request();
        wait_outcome(200, cyc, to);
        e = exp_q.pop_front();
        checks++;
        if (to || {o_PlaceFail, o_PlaceDone, o_FoodValid, o_FoodX, o_FoodY} !==
                  {e.fail, !e.fail, !e.fail, e.x, e.y}) begin
            fails++;
            $display("[TB] FAIL retry_outcome: got timeout=%b done=%b x=%0d y=%0d expected x=%0d y=%0d",
                     to, o_PlaceDone, o_FoodX, o_FoodY, e.x, e.y);
        end
        checks++;
        if (need_total - need_base != e.needs) begin
            fails++;
            $display("[TB] FAIL retry_needs: got %0d expected %0d", need_total - need_base, e.needs);
        end
    endtask

    task automatic test_exhaustion();
        int   cyc;
        bit   to;
        int   need_base;
        exp_t e;
        clear_map();
        occ_all = 1'b1;
        need_base = need_total;
        for (int i = 0; i < 16; i++) begin
            push_rand(5'($urandom_range(31, 0)), 5'($urandom_range(23, 0)));
        end
        exp_q.push_back('{1'b1, 5'd12, 5'd20, 16, -1});
        pulse_request();
        wait_outcome(400, cyc, to);
        e = exp_q.pop_front();
        checks++;
        if (to || {o_PlaceFail, o_PlaceDone, o_FoodValid, o_Busy, o_FoodX, o_FoodY} !==
                  {e.fail, !e.fail, !e.fail, !e.fail, e.x, e.y}) begin
            fails++;
            $display("[TB] FAIL exhaust_outcome: got timeout=%b fail=%b valid=%b busy=%b x=%0d y=%0d expected fail=1 x=%0d y=%0d",
                     to, o_PlaceFail, o_FoodValid, o_Busy, o_FoodX, o_FoodY, e.x, e.y);
        end
        checks++;
        if (need_total - need_base != e.needs) begin
            fails++;
            $display("[TB] FAIL exhaust_needs: got %0d expected %0d", need_total - need_base, e.needs);
        end
        occ_all = 1'b0;
    endtask

    task automatic test_watchdog();
        int   cyc;
        bit   to;
        int   need_base;
        exp_t e;
        clear_map();
        gen_enable = 1'b0;
        need_base = need_total;
        exp_q.push_back('{1'b1, 5'd12, 5'd20, 1, 18});
        pulse_request();
        wait_outcome(100, cyc, to);
        e = exp_q.pop_front();
        checks++;
        if (to || {o_PlaceFail, o_PlaceDone, o_FoodValid, o_Busy, o_FoodX, o_FoodY} !==
                  {e.fail, !e.fail, !e.fail, !e.fail, e.x, e.y}) begin
            fails++;
            $display("[TB] FAIL wdog_outcome: got timeout=%b fail=%b valid=%b busy=%b x=%0d y=%0d expected fail=1 busy=0",
                     to, o_PlaceFail, o_FoodValid, o_Busy, o_FoodX, o_FoodY);
        end
        checks++;
        if (cyc != e.latency) begin
            fails++;
            $display("[TB] FAIL wdog_latency: got %0d expected %0d", cyc, e.latency);
        end
        checks++;
        if (need_total - need_base != e.needs) begin
            fails++;
            $display("[TB] FAIL wdog_needs: got %0d expected %0d", need_total - need_base, e.needs);
        end
        gen_enable = 1'b1;
    endtask

    task automatic test_busy_ignore();
        int   cyc;
        bit   to;
        int   need_base;
        int   done_base;
        exp_t e;
        clear_map();
        need_base = need_total;
        done_base = done_total;
        push_rand(5'd6, 5'd7);
        exp_q.push_back('{1'b0, 5'd6, 5'd7, 1, -1});
        pulse_request();
        @(negedge i_Clk);
        i_PlaceReq = 1'b1;
        @(negedge i_Clk);
        i_PlaceReq = 1'b0;
        wait_outcome(60, cyc, to);
        e = exp_q.pop_front();
        checks++;
        if (to || {o_PlaceDone, o_FoodValid, o_FoodX, o_FoodY} !== {1'b1, 1'b1, e.x, e.y}) begin
            fails++;
            $display("[TB] FAIL busy_outcome: got timeout=%b done=%b x=%0d y=%0d expected x=%0d y=%0d",
                     to, o_PlaceDone, o_FoodX, o_FoodY, e.x, e.y);
        end
        repeat (12) @(negedge i_Clk);
        checks++;
        if (done_total - done_base != 1 || need_total - need_base != e.needs || o_Busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL busy_no_queue: got dones=%0d needs=%0d busy=%b expected dones=1 needs=1 busy=0",
                     done_total - done_base, need_total - need_base, o_Busy);
        end
    endtask

    task automatic test_reset_mid_op();
        int need_base;
        int done_base;
        int fail_base;
        clear_map();
        gen_enable = 1'b0;
        pulse_request();
        repeat (3) @(negedge i_Clk);
        i_PlaceReq = 1'b1;
        @(negedge i_Clk);
        i_PlaceReq = 1'b0;
        #2;
        i_Rst = 1'b1;
        #1;
        checks++;
        if ({o_FoodX, o_FoodY, o_QueryX, o_QueryY} !== 20'd0) begin
            fails++;
            $display("[TB] FAIL midrst_coords: got %h expected 00000",
                     {o_FoodX, o_FoodY, o_QueryX, o_QueryY});
        end
        checks++;
        if ({o_FoodValid, o_RandNeed, o_PlaceDone, o_PlaceFail, o_Busy} !== 5'b0) begin
            fails++;
            $display("[TB] FAIL midrst_flags: got %b expected 00000",
                     {o_FoodValid, o_RandNeed, o_PlaceDone, o_PlaceFail, o_Busy});
        end
        need_base = need_total;
        done_base = done_total;
        fail_base = fail_total;
        @(negedge i_Clk);
        i_Rst = 1'b0;
        gen_enable = 1'b1;
        repeat (20) @(negedge i_Clk);
        checks++;
        if (need_total != need_base || done_total != done_base || fail_total != fail_base || o_Busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midrst_quiet: got needs=%0d dones=%0d fails=%0d busy=%b expected all 0",
                     need_total - need_base, done_total - done_base, fail_total - fail_base, o_Busy);
        end
    endtask

    task automatic test_after_reset();
        int   cyc;
        bit   to;
        exp_t e;
        clear_map();
        push_rand(5'd17, 5'd3);
        exp_q.push_back('{1'b0, 5'd17, 5'd3, 1, 6});
        pulse_request();
        wait_outcome(60, cyc, to);
        e = exp_q.pop_front();
        checks++;
        if (to || cyc != e.latency ||
            {o_PlaceDone, o_FoodValid, o_FoodX, o_FoodY} !== {1'b1, 1'b1, e.x, e.y}) begin
            fails++;
            $display("[TB] FAIL post_reset_place: got timeout=%b cyc=%0d x=%0d y=%0d expected cyc=%0d x=%0d y=%0d",
                     to, cyc, o_FoodX, o_FoodY, e.latency, e.x, e.y);
        end
    endtask

    initial begin
        test_reset();
        test_free_placement();
        test_out_of_range();
        test_occupied_retry();
        test_exhaustion();
        test_watchdog();
        test_busy_ignore();
        test_reset_mid_op();
        test_after_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
